// File: rtl/canonical_pkg.sv
// Shared state codes, row type and literal encodings for the canonical-form scheduler.
package canonical_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StLoad    = 3'd0;
  localparam state_t StClear   = 3'd1;
  localparam state_t StIssue   = 3'd2;
  localparam state_t StCollect = 3'd3;
  localparam state_t StEmit    = 3'd4;

  localparam int unsigned DefNumQubit  = 4;
  localparam int unsigned DefMaxVector = 2 ** DefNumQubit;

  typedef struct packed {
    logic [2*DefNumQubit-1:0] literals;
    logic [DefMaxVector-1:0]  phase;
  } row_t;

  // Two-bit Pauli literal codes shared with the reduction datapath.
  localparam logic [1:0] LitI = 2'b00;
  localparam logic [1:0] LitX = 2'b01;
  localparam logic [1:0] LitZ = 2'b10;
  localparam logic [1:0] LitY = 2'b11;

endpackage

// File: rtl/canonical_row_buf.sv
// Depth-deep row register file: one synchronous write port, one combinational read port.
module canonical_row_buf #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 24,
  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk,
  input  logic             rst_new,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk or posedge rst_new) begin
    if (rst_new) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/canonical_scheduler.sv
// Buffers one tableau, streams it gap-free into the canonical datapath, replays the results.
// Optional collect watchdog enabled by defining CANON_SCHED_TIMEOUT_EN.
module canonical_scheduler
  import canonical_pkg::*;
#(
  parameter int unsigned num_qubit      = 4,
  parameter int unsigned max_vector     = 2 ** num_qubit,
  parameter int unsigned TIMEOUT_CYCLES = 8 * num_qubit
) (
  input  logic                   clk,
  input  logic                   rst_new,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [2*num_qubit-1:0] s_literals,
  input  logic [max_vector-1:0]  s_phase,
  output logic                   canon_clear,
  output logic                   canon_valid,
  output logic [2*num_qubit-1:0] canon_literals,
  output logic [max_vector-1:0]  canon_phase,
  input  logic                   canon_flag,
  input  logic [2*num_qubit-1:0] canon_literals_out,
  input  logic [max_vector-1:0]  canon_phase_out,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [2*num_qubit-1:0] m_literals,
  output logic [max_vector-1:0]  m_phase,
  output logic                   m_last,
  output logic                   busy,
  output logic                   err_timeout
);

  localparam int unsigned LitW  = 2 * num_qubit;
  localparam int unsigned RowW  = LitW + max_vector;
  localparam int unsigned CntW  = $clog2(num_qubit + 1);
  localparam int unsigned AddrW = (num_qubit > 1) ? $clog2(num_qubit) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(num_qubit - 1);

  state_t          state_q, state_d;
  logic [CntW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CntW-1:0] iss_cnt_q, iss_cnt_d;
  logic [CntW-1:0] col_cnt_q, col_cnt_d;
  logic [CntW-1:0] rd_cnt_q, rd_cnt_d;
  logic            started_q;

  logic            in_we, capture, wd_fire;
  logic [RowW-1:0] in_rdata, out_rdata;

  assign capture = (state_q == StCollect) && canon_flag;

  // Holds s_ready low until the first clock after reset release.
  always_ff @(posedge clk or posedge rst_new) begin
    if (rst_new) begin
      started_q <= 1'b0;
    end else begin
      started_q <= 1'b1;
    end
  end

`ifdef CANON_SCHED_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WdW-1:0] wd_q, wd_d;

  assign wd_fire = (state_q == StCollect) && !canon_flag && (wd_q == WdW'(TIMEOUT_CYCLES));

  always_comb begin
    wd_d = wd_q + WdW'(1);
    if ((state_q != StCollect) || capture || wd_fire) begin
      wd_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst_new) begin
    if (rst_new) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
  assign wd_fire        = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    iss_cnt_d = iss_cnt_q;
    col_cnt_d = col_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    in_we     = 1'b0;
    unique case (state_q)
      StLoad: begin
        if (s_valid && s_ready) begin
          in_we = 1'b1;
          if (wr_cnt_q == LastIdx) begin
            wr_cnt_d = '0;
            state_d  = StClear;
          end else begin
            wr_cnt_d = wr_cnt_q + CntW'(1);
          end
        end
      end
      StClear: state_d = StIssue;
      StIssue: begin
        if (iss_cnt_q == LastIdx) begin
          iss_cnt_d = '0;
          state_d   = StCollect;
        end else begin
          iss_cnt_d = iss_cnt_q + CntW'(1);
        end
      end
      StCollect: begin
        if (capture) begin
          if (col_cnt_q == LastIdx) begin
            col_cnt_d = '0;
            state_d   = StEmit;
          end else begin
            col_cnt_d = col_cnt_q + CntW'(1);
          end
        end else if (wd_fire) begin
          // Abandon the partial result set; captured rows are never emitted.
          col_cnt_d = '0;
          state_d   = StLoad;
        end
      end
      StEmit: begin
        if (m_ready) begin
          if (rd_cnt_q == LastIdx) begin
            rd_cnt_d = '0;
            state_d  = StLoad;
          end else begin
            rd_cnt_d = rd_cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk or posedge rst_new) begin
    if (rst_new) begin
      state_q   <= StLoad;
      wr_cnt_q  <= '0;
      iss_cnt_q <= '0;
      col_cnt_q <= '0;
      rd_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      iss_cnt_q <= iss_cnt_d;
      col_cnt_q <= col_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
    end
  end

  canonical_row_buf #(
    .Depth (num_qubit),
    .Width (RowW)
  ) u_in_buf (
    .clk     (clk),
    .rst_new (rst_new),
    .we_i    (in_we),
    .waddr_i (wr_cnt_q[AddrW-1:0]),
    .wdata_i ({s_literals, s_phase}),
    .raddr_i (iss_cnt_q[AddrW-1:0]),
    .rdata_o (in_rdata)
  );

  canonical_row_buf #(
    .Depth (num_qubit),
    .Width (RowW)
  ) u_out_buf (
    .clk     (clk),
    .rst_new (rst_new),
    .we_i    (capture),
    .waddr_i (col_cnt_q[AddrW-1:0]),
    .wdata_i ({canon_literals_out, canon_phase_out}),
    .raddr_i (rd_cnt_q[AddrW-1:0]),
    .rdata_o (out_rdata)
  );

  assign s_ready     = (state_q == StLoad) && started_q;
  assign busy        = (state_q != StLoad);
  assign canon_clear = (state_q == StClear) || wd_fire;
  assign err_timeout = wd_fire;

  assign canon_valid                   = (state_q == StIssue);
  assign {canon_literals, canon_phase} = canon_valid ? in_rdata : '0;

  assign m_valid               = (state_q == StEmit);
  assign {m_literals, m_phase} = m_valid ? out_rdata : '0;
  assign m_last                = m_valid && (rd_cnt_q == LastIdx);

endmodule

// File: tb/tb_canonical_scheduler.sv
// Self-checking bench for canonical_scheduler with queue-based scoreboards for issue and emit.
module tb_canonical_scheduler;

  localparam int unsigned NQ = 4;
  localparam int unsigned MV = 2 ** NQ;
  localparam int unsigned LW = 2 * NQ;
  localparam int unsigned RW = LW + MV;

  logic          clk = 1'b0;
  logic          rst_new;
  logic          s_valid, s_ready;
  logic [LW-1:0] s_literals;
  logic [MV-1:0] s_phase;
  logic          canon_clear, canon_valid;
  logic [LW-1:0] canon_literals;
  logic [MV-1:0] canon_phase;
  logic          canon_flag;
  logic [LW-1:0] canon_literals_out;
  logic [MV-1:0] canon_phase_out;
  logic          m_valid, m_ready, m_last, busy, err_timeout;
  logic [LW-1:0] m_literals;
  logic [MV-1:0] m_phase;

  int n_checks = 0;
  int n_pass   = 0;
  logic [RW-1:0] iss_q[$];
  logic [RW-1:0] emit_q[$];

  always #5 clk = ~clk;

  canonical_scheduler #(
    .num_qubit (NQ)
  ) dut (
    .clk                (clk),
    .rst_new            (rst_new),
    .s_valid            (s_valid),
    .s_ready            (s_ready),
    .s_literals         (s_literals),
    .s_phase            (s_phase),
    .canon_clear        (canon_clear),
    .canon_valid        (canon_valid),
    .canon_literals     (canon_literals),
    .canon_phase        (canon_phase),
    .canon_flag         (canon_flag),
    .canon_literals_out (canon_literals_out),
    .canon_phase_out    (canon_phase_out),
    .m_valid            (m_valid),
    .m_ready            (m_ready),
    .m_literals         (m_literals),
    .m_phase            (m_phase),
    .m_last             (m_last),
    .busy               (busy),
    .err_timeout        (err_timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] got;
    rst_new = 1'b1; s_valid = 1'b0; s_literals = '0; s_phase = '0;
    canon_flag = 1'b0; canon_literals_out = '0; canon_phase_out = '0; m_ready = 1'b0;
    tick(); tick();
    got = {s_ready, canon_clear, canon_valid, m_valid, m_last, busy, err_timeout};
    n_checks++;
    if (got !== 7'b0 || canon_literals !== '0 || m_literals !== '0) begin
      $display("FAIL reset_outputs got=%b want=0000000", got);
    end else n_pass++;
    rst_new = 1'b0;
    #1;
    n_checks++;
    if (s_ready !== 1'b0) $display("FAIL ready_before_clock got=%b want=0", s_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL ready_after_clock got=%b/%b want=1/0", s_ready, busy);
    end else n_pass++;
  endtask

  // Feeds NQ rows, optionally with idle cycles between them; leaves the DUT in CLEAR.
  task automatic load_tableau(input bit gaps);
    for (int i = 0; i < int'(NQ); i++) begin
      if (gaps) begin
        s_valid = 1'b0;
        for (int g = 0; g <= i % 2; g++) tick();
      end
      s_valid    = 1'b1;
      s_literals = LW'($urandom);
      s_phase    = MV'($urandom);
      n_checks++;
      if (s_ready !== 1'b1) $display("FAIL load_ready row=%0d got=%b want=1", i, s_ready);
      else n_pass++;
      iss_q.push_back({s_literals, s_phase});
      tick();
    end
    s_valid = 1'b0;
  endtask

  // Checks CLEAR then NQ bubble-free issue cycles while upstream and flag inputs are noisy.
  task automatic test_issue();
    logic [RW-1:0] exp;
    n_checks++;
    if (canon_clear !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b1 || canon_valid !== 1'b0) begin
      $display("FAIL clear_cycle got clr=%b rdy=%b busy=%b cv=%b want 1/0/1/0",
               canon_clear, s_ready, busy, canon_valid);
    end else n_pass++;
    s_valid = 1'b1; s_literals = '1; s_phase = '1;
    canon_flag = 1'b1; canon_literals_out = '1; canon_phase_out = '1;
    tick();
    for (int k = 0; k < int'(NQ); k++) begin
      exp = iss_q.pop_front();
      n_checks++;
      if (canon_valid !== 1'b1 || {canon_literals, canon_phase} !== exp ||
          canon_clear !== 1'b0 || s_ready !== 1'b0) begin
        $display("FAIL issue_row k=%0d got v=%b row=%h clr=%b rdy=%b want v=1 row=%h clr=0 rdy=0",
                 k, canon_valid, {canon_literals, canon_phase}, canon_clear, s_ready, exp);
      end else n_pass++;
      tick();
    end
    canon_flag = 1'b0; s_valid = 1'b0;
    n_checks++;
    if (canon_valid !== 1'b0 || canon_literals !== '0 || canon_phase !== '0 || m_valid !== 1'b0) begin
      $display("FAIL issue_end got v=%b lit=%h ph=%h mv=%b want 0/0/0/0",
               canon_valid, canon_literals, canon_phase, m_valid);
    end else n_pass++;
  endtask

  task automatic test_collect(input bit scattered);
    for (int k = 0; k < int'(NQ); k++) begin
      if (scattered) begin
        for (int g = 0; g < (k * 2) % 3 + 1; g++) tick();
      end
      canon_flag         = 1'b1;
      canon_literals_out = LW'($urandom);
      canon_phase_out    = MV'($urandom);
      emit_q.push_back({canon_literals_out, canon_phase_out});
      tick();
      canon_flag = 1'b0;
      if (k < int'(NQ) - 1) begin
        n_checks++;
        if (m_valid !== 1'b0) $display("FAIL collect_early_emit k=%0d got=%b want=0", k, m_valid);
        else n_pass++;
      end
    end
  endtask

  task automatic test_emit(input int stall_row, input int stall_len);
    logic [RW-1:0] exp;
    s_valid = 1'b1; s_literals = '1; s_phase = '1;
    for (int r = 0; r < int'(NQ); r++) begin
      exp = emit_q[0];
      n_checks++;
      if (m_valid !== 1'b1 || {m_literals, m_phase} !== exp || m_last !== (r == int'(NQ) - 1) ||
          s_ready !== 1'b0 || busy !== 1'b1) begin
        $display("FAIL emit_row r=%0d got v=%b row=%h last=%b rdy=%b want v=1 row=%h last=%b rdy=0",
                 r, m_valid, {m_literals, m_phase}, m_last, s_ready, exp, r == int'(NQ) - 1);
      end else n_pass++;
      if (r == stall_row) begin
        m_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          n_checks++;
          if (m_valid !== 1'b1 || {m_literals, m_phase} !== exp || m_last !== 1'b0) begin
            $display("FAIL emit_stall s=%0d got v=%b row=%h last=%b want v=1 row=%h last=0",
                     s, m_valid, {m_literals, m_phase}, m_last, exp);
          end else n_pass++;
        end
      end
      m_ready = 1'b1;
      tick();
      void'(emit_q.pop_front());
    end
    m_ready = 1'b0; s_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || s_ready !== 1'b1 || m_valid !== 1'b0 || emit_q.size() != 0) begin
      $display("FAIL emit_done got busy=%b rdy=%b mv=%b left=%0d want 0/1/0/0",
               busy, s_ready, m_valid, emit_q.size());
    end else n_pass++;
  endtask

  task automatic test_reset_mid_issue();
    int seen;
    load_tableau(1'b0);
    tick();
    tick();
    n_checks++;
    if (canon_valid !== 1'b1) $display("FAIL mid_reset_in_issue got=%b want=1", canon_valid);
    else n_pass++;
    #2 rst_new = 1'b1;
    #1;
    n_checks++;
    if (canon_valid !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0) begin
      $display("FAIL mid_reset_async got cv=%b mv=%b busy=%b rdy=%b want 0/0/0/0",
               canon_valid, m_valid, busy, s_ready);
    end else n_pass++;
    tick();
    rst_new = 1'b0;
    iss_q.delete();
    tick();
    n_checks++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL mid_reset_release got rdy=%b busy=%b want 1/0", s_ready, busy);
    end else n_pass++;
    seen = 0;
    for (int c = 0; c < 2 * int'(NQ); c++) begin
      canon_flag = 1'b1; canon_literals_out = LW'($urandom); canon_phase_out = MV'($urandom);
      tick();
      if (m_valid || canon_valid) seen++;
    end
    canon_flag = 1'b0;
    n_checks++;
    if (seen != 0 || busy !== 1'b0) begin
      $display("FAIL mid_reset_no_emit got seen=%0d busy=%b want 0/0", seen, busy);
    end else n_pass++;
  endtask

`ifdef CANON_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    load_tableau(1'b0);
    test_issue();
    for (int k = 0; k < 2; k++) begin
      canon_flag = 1'b1; canon_literals_out = LW'($urandom); canon_phase_out = MV'($urandom);
      tick();
      canon_flag = 1'b0;
    end
    n = 0;
    while (err_timeout !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    n_checks++;
    if (n != 8 * int'(NQ) || canon_clear !== 1'b1) begin
      $display("FAIL timeout_pulse got cycles=%0d clr=%b want %0d/1", n, canon_clear, 8 * NQ);
    end else n_pass++;
    tick();
    n_checks++;
    if (err_timeout !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b1 || m_valid !== 1'b0) begin
      $display("FAIL timeout_return got err=%b busy=%b rdy=%b mv=%b want 0/0/1/0",
               err_timeout, busy, s_ready, m_valid);
    end else n_pass++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global_time_limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    test_reset();
    load_tableau(1'b1);
    test_issue();
    test_collect(1'b1);
    test_emit(1, 5);
    test_reset_mid_issue();
    load_tableau(1'b0);
    test_issue();
    test_collect(1'b0);
    test_emit(-1, 0);
`ifdef CANON_SCHED_TIMEOUT_EN
    test_timeout();
`else
    n_checks++;
    if (err_timeout !== 1'b0) $display("FAIL timeout_tied got=%b want=0", err_timeout);
    else n_pass++;
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
